dma: RTL

Single-channel word DMA engine that copies a block of 32-bit words from a source address to a destination address over the system memory bus. It has two sides. As a responder, it is decoded at a base address in the SoC memory map; software programs it there through `mem_in_type`/`mem_out_type`. As an initiator, it issues its own read and write requests on a second bus port, which feeds an arbiter input alongside the CPU ports. The engine raises an optional interrupt when a transfer completes.

---
 rtl/dma.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dma.sv
// Single-channel word DMA: register responder port plus bus initiator port.
// Optional transfer-complete interrupt enabled by defining DMA_IRQ_EN.
package configure;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;

  localparam mem_in_type  init_mem_in  = '0;
  localparam mem_out_type init_mem_out = '0;
endpackage

module dma
  import configure::*;
(
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  cfg_in,
  output mem_out_type cfg_out,
  output mem_in_type  mst_in,
  input  mem_out_type mst_out,
  output logic        dma_irpt
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t      state;
  logic [31:0] src, dst, cur_src, cur_dst;
  logic [15:0] len, remaining;
  logic        done, err, ie, busy;
  logic        cfg_wr, ctrl_wr;
  logic [1:0]  sel;
  logic [31:0] rd_mux;
  logic        unused_cfg;

  assign busy       = (state != IDLE);
  assign unused_cfg = ^{cfg_in.mem_instr, cfg_in.mem_addr[31:4], cfg_in.mem_addr[1:0]};

  always_comb begin
    sel     = cfg_in.mem_addr[3:2];
    cfg_wr  = cfg_in.mem_valid && (cfg_in.mem_wstrb != 4'h0);
    ctrl_wr = cfg_wr && (sel == 2'd3);
    rd_mux  = '0;
    case (sel)
      2'd0: rd_mux = src;
      2'd1: rd_mux = dst;
      2'd2: rd_mux = {16'h0000, len};
      2'd3: rd_mux = {28'h0, ie, err, done, busy};
      default: rd_mux = '0;
    endcase
  end

  // The registered write request doubles as the data buffer between read and write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cfg_out   <= init_mem_out;
      mst_in    <= init_mem_in;
    end else begin
      cfg_out <= init_mem_out;
      mst_in  <= init_mem_in;
      if (cfg_in.mem_valid) begin
        cfg_out.mem_ready <= 1'b1;
        cfg_out.mem_rdata <= rd_mux;
      end
      if (cfg_wr && !busy) begin
        case (sel)
          2'd0: src <= {cfg_in.mem_wdata[31:2], 2'b00};
          2'd1: dst <= {cfg_in.mem_wdata[31:2], 2'b00};
          2'd2: len <= cfg_in.mem_wdata[15:0];
          default: ;
        endcase
      end
      if (ctrl_wr && cfg_in.mem_wdata[1]) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (ctrl_wr && cfg_in.mem_wdata[0]) begin
            if (len == 16'h0000) begin
              done <= 1'b1;
            end else begin
              cur_src          <= src;
              cur_dst          <= dst;
              remaining        <= len;
              done             <= 1'b0;
              err              <= 1'b0;
              state            <= RD_REQ;
              mst_in.mem_valid <= 1'b1;
              mst_in.mem_addr  <= src;
            end
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          if (mst_out.mem_ready) begin
            if (mst_out.mem_error) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state            <= WR_REQ;
              mst_in.mem_valid <= 1'b1;
              mst_in.mem_addr  <= cur_dst;
              mst_in.mem_wdata <= mst_out.mem_rdata;
              mst_in.mem_wstrb <= 4'hF;
            end
          end
        end
        WR_REQ: state <= WR_WAIT;
        WR_WAIT: begin
          if (mst_out.mem_ready) begin
            if (mst_out.mem_error) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cur_src   <= cur_src + 32'd4;
              cur_dst   <= cur_dst + 32'd4;
              remaining <= remaining - 16'd1;
              if (remaining == 16'd1) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state            <= RD_REQ;
                mst_in.mem_valid <= 1'b1;
                mst_in.mem_addr  <= cur_src + 32'd4;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_IRQ_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      ie       <= 1'b0;
      dma_irpt <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= cfg_in.mem_wdata[3];
      dma_irpt <= done & ie;
    end
  end
`else
  assign ie       = 1'b0;
  assign dma_irpt = 1'b0;
`endif

endmodule
